// File: rtl/trn_rx_tlp_buffer_pkg.sv
// Shared types for the TRN RX store-and-forward buffer.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
//
// Beat record stored per RAM entry (74 bits). Field offsets, LSB first:
//   data [63:0], rem_n [64], eof [65], errfwd [66], bar_hit_n [73:67].
// No sof bit is stored. Only whole TLPs are ever committed, so the output
// stage rebuilds sof as "first beat after an eof".
package trn_rx_tlp_buffer_pkg;

  localparam int BEAT_W = 74;

  typedef struct packed {
    logic [6:0]  bar_hit_n;
    logic        errfwd;
    logic        eof;
    logic        rem_n;
    logic [63:0] data;
  } beat_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PKT  = 2'd1,
    ST_DROP = 2'd2
  } rx_state_e;

endpackage

// File: rtl/trn_rx_tlp_buffer_if.sv
// Bus bundle between the TRN RX port, the buffer and the TLP consumer.
// Latency: n/a (wiring only).
// Backpressure: trn_rdst_rdy_n (active-low) on RX; tlp_valid/tlp_ready on TX.
//
// Modports:
//   slave  - the buffer: receives the trn_* beat, drives trn_rdst_rdy_n,
//            and drives the tlp_* stream.
//   master - the environment: drives the trn_* beat and tlp_ready.
interface trn_rx_tlp_buffer_if;
  logic [63:0] trn_rd;
  logic        trn_rrem_n;
  logic        trn_rsof_n;
  logic        trn_reof_n;
  logic        trn_rsrc_rdy_n;
  logic        trn_rsrc_dsc_n;
  logic        trn_rerrfwd_n;
  logic [6:0]  trn_rbar_hit_n;
  logic        trn_rdst_rdy_n;

  logic [63:0] tlp_data;
  logic        tlp_sof;
  logic        tlp_eof;
  logic        tlp_rem_n;
  logic        tlp_errfwd;
  logic [6:0]  tlp_bar_hit_n;
  logic        tlp_valid;
  logic        tlp_ready;

  modport slave (
    input  trn_rd, trn_rrem_n, trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n,
           trn_rsrc_dsc_n, trn_rerrfwd_n, trn_rbar_hit_n, tlp_ready,
    output trn_rdst_rdy_n, tlp_data, tlp_sof, tlp_eof, tlp_rem_n,
           tlp_errfwd, tlp_bar_hit_n, tlp_valid
  );

  modport master (
    output trn_rd, trn_rrem_n, trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n,
           trn_rsrc_dsc_n, trn_rerrfwd_n, trn_rbar_hit_n, tlp_ready,
    input  trn_rdst_rdy_n, tlp_data, tlp_sof, tlp_eof, tlp_rem_n,
           tlp_errfwd, tlp_bar_hit_n, tlp_valid
  );
endinterface

// File: rtl/trn_rx_tlp_buffer_ram.sv
// Simple dual-port beat store, DEPTH x WIDTH, one write port and one read port.
// Latency: one cycle, sync write and sync read; rd_dat holds while rd_en=0.
// Backpressure: none; the caller guarantees it never reads an entry being written.
//
// Ports: clk; wr_en/wr_addr/wr_dat write side; rd_en/rd_addr/rd_dat read side.
module trn_rx_tlp_buffer_ram #(
  parameter int DEPTH_LOG2 = 5,
  parameter int WIDTH      = 74
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_dat,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_dat
);

  logic [WIDTH-1:0] mem_q [2**DEPTH_LOG2];
  logic [WIDTH-1:0] rd_dat_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_dat;
    if (rd_en) rd_dat_q <= mem_q[rd_addr];
  end

  assign rd_dat = rd_dat_q;

endmodule

// File: rtl/trn_rx_tlp_buffer.sv
// Store-and-forward buffer behind the PCIe TRN RX port. It releases only complete, good TLPs.
// Latency: eof accepted at edge N gives the first beat on tlp_valid after edge N+2 (empty buffer).
// Backpressure: trn_rdst_rdy_n is registered; it goes high when the buffer is full or the link is down.
//
// Ports: trn_clk, trn_reset_n (sync, active-low), trn_lnk_up_n (active-low);
//        trn_if (slave modport) carries the TRN RX beat plus the tlp_* stream;
//        err_pulse pulses for one cycle on every drop or protocol error.
// Optional: define TRN_RX_STATS_EN to add stat_tlp_cnt / stat_drop_cnt.
//           Both are saturating 32-bit counts.
module trn_rx_tlp_buffer
  import trn_rx_tlp_buffer_pkg::*;
#(
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                 trn_clk,
  input  logic                 trn_reset_n,
  input  logic                 trn_lnk_up_n,
  trn_rx_tlp_buffer_if.slave   trn_if,
  output logic                 err_pulse
`ifdef TRN_RX_STATS_EN
  ,
  output logic [31:0]          stat_tlp_cnt,
  output logic [31:0]          stat_drop_cnt
`endif
);

  localparam int PW = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] DEPTH_V  = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [PW-1:0] LEN_LAST = DEPTH_V - PW'(1);

  rx_state_e       state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   commit_ptr_q, commit_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;       // released on consumer transfer
  logic [PW-1:0]   fetch_ptr_q, fetch_ptr_d; // next RAM entry to pull
  logic            rdst_rdy_n_q, rdst_rdy_n_d;
  logic            err_q, err_d;
  logic [6:0]      bar_q, bar_d;
  logic            s1_vld_q, s1_vld_d;       // RAM read register holds a beat
  logic            out_first_q, out_first_d; // next beat loaded starts a TLP
  logic            tlp_valid_q, tlp_valid_d;
  logic            tlp_sof_q, tlp_sof_d;
  beat_t           tlp_beat_q, tlp_beat_d;

  logic            beat, sof, eof, dsc, len_hit;
  logic [PW-1:0]   pkt_len, used_next;
  logic            wr_en, rd_en, s2_take, xfer;
  logic [DEPTH_LOG2-1:0] wr_addr;
  beat_t           wr_beat, ram_beat;

  // Decode of the RX beat. While the link is down, incoming beats are ignored.
  assign beat    = ~trn_if.trn_rsrc_rdy_n & ~rdst_rdy_n_q & ~trn_lnk_up_n;
  assign sof     = ~trn_if.trn_rsof_n;
  assign eof     = ~trn_if.trn_reof_n;
  assign dsc     = ~trn_if.trn_rsrc_dsc_n;
  assign pkt_len = wr_ptr_q - commit_ptr_q;
  // One more non-eof beat would make the packet fill the whole buffer.
  assign len_hit = (pkt_len == LEN_LAST);

  always_comb begin
    wr_beat           = '0;
    wr_beat.data      = trn_if.trn_rd;
    wr_beat.rem_n     = trn_if.trn_rrem_n;
    wr_beat.eof       = eof;
    wr_beat.errfwd    = ~trn_if.trn_rerrfwd_n;
    wr_beat.bar_hit_n = sof ? trn_if.trn_rbar_hit_n : bar_q;
  end

  // ---------------- RX FSM: state register ----------------
  always_ff @(posedge trn_clk) begin
    if (!trn_reset_n) state_q <= ST_IDLE;
    else              state_q <= state_d;
  end

  // ---------------- RX FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    if (trn_lnk_up_n) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (beat && sof && !eof) state_d = ST_PKT;
        ST_PKT: begin
          if (dsc) begin
            state_d = ST_IDLE;
          end else if (beat) begin
            if (eof)                 state_d = ST_IDLE;
            else if (!sof && len_hit) state_d = ST_DROP;
          end
        end
        ST_DROP: if (dsc || (beat && eof)) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------- RX FSM: outputs (write, pointers, error) ----------------
  always_comb begin
    wr_en        = 1'b0;
    wr_addr      = wr_ptr_q[DEPTH_LOG2-1:0];
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    err_d        = 1'b0;
    bar_d        = (beat && sof) ? trn_if.trn_rbar_hit_n : bar_q;
    if (trn_lnk_up_n) begin
      // Committed TLPs stay queued; only the partial packet is thrown away.
      wr_ptr_d = commit_ptr_q;
      err_d    = (state_q == ST_PKT);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (beat) begin
            if (sof) begin
              wr_en    = 1'b1;
              wr_ptr_d = wr_ptr_q + PW'(1);
              if (eof) commit_ptr_d = wr_ptr_q + PW'(1);
            end else begin
              err_d = 1'b1;
            end
          end
        end
        ST_PKT: begin
          if (dsc) begin
            wr_ptr_d = commit_ptr_q;
            err_d    = 1'b1;
          end else if (beat) begin
            if (sof) begin
              // A new sof arrived mid-packet. Drop the partial packet and restart at the commit point.
              err_d    = 1'b1;
              wr_en    = 1'b1;
              wr_addr  = commit_ptr_q[DEPTH_LOG2-1:0];
              wr_ptr_d = commit_ptr_q + PW'(1);
              if (eof) commit_ptr_d = commit_ptr_q + PW'(1);
            end else if (eof) begin
              wr_en        = 1'b1;
              wr_ptr_d     = wr_ptr_q + PW'(1);
              commit_ptr_d = wr_ptr_q + PW'(1);
            end else if (len_hit) begin
              wr_ptr_d = commit_ptr_q;
              err_d    = 1'b1;
            end else begin
              wr_en    = 1'b1;
              wr_ptr_d = wr_ptr_q + PW'(1);
            end
          end
        end
        ST_DROP: if (dsc) err_d = 1'b1;
        default: ;
      endcase
    end
  end

  // ---------------- Read side: RAM read register + output register ----------------
  assign s2_take = s1_vld_q & (~tlp_valid_q | trn_if.tlp_ready);
  assign xfer    = tlp_valid_q & trn_if.tlp_ready;
  assign rd_en   = (fetch_ptr_q != commit_ptr_q) & (~s1_vld_q | s2_take);

  always_comb begin
    fetch_ptr_d = fetch_ptr_q;
    s1_vld_d    = s1_vld_q;
    rd_ptr_d    = rd_ptr_q;
    tlp_valid_d = tlp_valid_q;
    tlp_beat_d  = tlp_beat_q;
    tlp_sof_d   = tlp_sof_q;
    out_first_d = out_first_q;
    if (xfer) rd_ptr_d = rd_ptr_q + PW'(1);
    if (s2_take) begin
      s1_vld_d    = 1'b0;
      tlp_valid_d = 1'b1;
      tlp_beat_d  = ram_beat;
      tlp_sof_d   = out_first_q;
      out_first_d = ram_beat.eof;
    end else if (xfer) begin
      tlp_valid_d = 1'b0;
    end
    if (rd_en) begin
      fetch_ptr_d = fetch_ptr_q + PW'(1);
      s1_vld_d    = 1'b1;
    end
  end

  // Entries in the output stages still count as used until the consumer takes them.
  assign used_next    = wr_ptr_d - rd_ptr_d;
  assign rdst_rdy_n_d = (used_next == DEPTH_V) | trn_lnk_up_n;

  always_ff @(posedge trn_clk) begin
    if (!trn_reset_n) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      fetch_ptr_q  <= '0;
      rdst_rdy_n_q <= 1'b1;
      err_q        <= 1'b0;
      bar_q        <= '0;
      s1_vld_q     <= 1'b0;
      out_first_q  <= 1'b1;
      tlp_valid_q  <= 1'b0;
      tlp_sof_q    <= 1'b0;
      tlp_beat_q   <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fetch_ptr_q  <= fetch_ptr_d;
      rdst_rdy_n_q <= rdst_rdy_n_d;
      err_q        <= err_d;
      bar_q        <= bar_d;
      s1_vld_q     <= s1_vld_d;
      out_first_q  <= out_first_d;
      tlp_valid_q  <= tlp_valid_d;
      tlp_sof_q    <= tlp_sof_d;
      tlp_beat_q   <= tlp_beat_d;
    end
  end

  trn_rx_tlp_buffer_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (BEAT_W)
  ) u_ram (
    .clk     (trn_clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_dat  (wr_beat),
    .rd_en   (rd_en),
    .rd_addr (fetch_ptr_q[DEPTH_LOG2-1:0]),
    .rd_dat  (ram_beat)
  );

  assign trn_if.trn_rdst_rdy_n = rdst_rdy_n_q;
  assign trn_if.tlp_data       = tlp_beat_q.data;
  assign trn_if.tlp_sof        = tlp_sof_q;
  assign trn_if.tlp_eof        = tlp_beat_q.eof;
  assign trn_if.tlp_rem_n      = tlp_beat_q.rem_n;
  assign trn_if.tlp_errfwd     = tlp_beat_q.errfwd;
  assign trn_if.tlp_bar_hit_n  = tlp_beat_q.bar_hit_n;
  assign trn_if.tlp_valid      = tlp_valid_q;
  assign err_pulse             = err_q;

`ifdef TRN_RX_STATS_EN
  logic [31:0] stat_tlp_cnt_q, stat_tlp_cnt_d;
  logic [31:0] stat_drop_cnt_q, stat_drop_cnt_d;

  always_comb begin
    stat_tlp_cnt_d  = stat_tlp_cnt_q;
    stat_drop_cnt_d = stat_drop_cnt_q;
    if ((commit_ptr_d != commit_ptr_q) && (stat_tlp_cnt_q != 32'hFFFF_FFFF))
      stat_tlp_cnt_d = stat_tlp_cnt_q + 32'd1;
    if (err_d && (stat_drop_cnt_q != 32'hFFFF_FFFF))
      stat_drop_cnt_d = stat_drop_cnt_q + 32'd1;
  end

  always_ff @(posedge trn_clk) begin
    if (!trn_reset_n) begin
      stat_tlp_cnt_q  <= '0;
      stat_drop_cnt_q <= '0;
    end else begin
      stat_tlp_cnt_q  <= stat_tlp_cnt_d;
      stat_drop_cnt_q <= stat_drop_cnt_d;
    end
  end

  assign stat_tlp_cnt  = stat_tlp_cnt_q;
  assign stat_drop_cnt = stat_drop_cnt_q;
`endif

endmodule

// File: tb/tb_trn_rx_tlp_buffer.sv
// Directed bench for trn_rx_tlp_buffer built with DEPTH_LOG2=4 (16-beat buffer).
// Inputs change 1ns after the rising edge. Outputs are sampled on the falling edge.
// A monitor records each TLP-stream transfer and counts err_pulse cycles.
module tb_trn_rx_tlp_buffer;

  logic clk = 1'b0;
  logic trn_reset_n;
  logic trn_lnk_up_n;
  logic err_pulse;
`ifdef TRN_RX_STATS_EN
  logic [31:0] stat_tlp_cnt, stat_drop_cnt;
`endif

  trn_rx_tlp_buffer_if bus ();

  trn_rx_tlp_buffer #(.DEPTH_LOG2(4)) dut (
    .trn_clk      (clk),
    .trn_reset_n  (trn_reset_n),
    .trn_lnk_up_n (trn_lnk_up_n),
    .trn_if       (bus),
    .err_pulse    (err_pulse)
`ifdef TRN_RX_STATS_EN
    ,
    .stat_tlp_cnt (stat_tlp_cnt),
    .stat_drop_cnt(stat_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] d;
    logic [3:0]  flags;  // {sof, eof, rem_n, errfwd}
    logic [6:0]  bar;
  } obs_t;

  obs_t obs_q[$];
  int   err_cnt;
  int   checks = 0;
  int   errors = 0;

  always @(negedge clk) begin
    if (trn_reset_n && bus.tlp_valid && bus.tlp_ready) begin
      obs_t o;
      o.d     = bus.tlp_data;
      o.flags = {bus.tlp_sof, bus.tlp_eof, bus.tlp_rem_n, bus.tlp_errfwd};
      o.bar   = bus.tlp_bar_hit_n;
      obs_q.push_back(o);
    end
    if (trn_reset_n && err_pulse) err_cnt++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one beat and holds it until it is accepted. Returns 1ns after the accepting edge.
  task automatic send(input logic [63:0] d, input logic sof, input logic eof,
                      input logic rem_n, input logic dsc, input logic errf,
                      input logic [6:0] bar);
    int n = 0;
    bus.trn_rd          = d;
    bus.trn_rsof_n      = ~sof;
    bus.trn_reof_n      = ~eof;
    bus.trn_rrem_n      = rem_n;
    bus.trn_rsrc_dsc_n  = ~dsc;
    bus.trn_rerrfwd_n   = ~errf;
    bus.trn_rbar_hit_n  = bar;
    bus.trn_rsrc_rdy_n  = 1'b0;
    @(negedge clk);
    while (bus.trn_rdst_rdy_n && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check_eq("rx_accept_timeout", bus.trn_rdst_rdy_n, 0);
    tick();
    bus.trn_rsrc_rdy_n = 1'b1;
    bus.trn_rsrc_dsc_n = 1'b1;
  endtask

  task automatic drain(input int n);
    bus.tlp_ready = 1'b1;
    repeat (n) tick();
    bus.tlp_ready = 1'b0;
  endtask

  task automatic expect_beat(input string tag, input logic [63:0] d,
                             input logic [3:0] flags, input logic [6:0] bar);
    obs_t o;
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      check_eq({tag, "_data"}, o.d, d);
      check_eq({tag, "_flags"}, o.flags, flags);
      check_eq({tag, "_bar"}, o.bar, bar);
    end else begin
      check_eq({tag, "_missing"}, obs_q.size(), 1);
    end
  endtask

  task automatic clear_obs();
    obs_q.delete();
    err_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    trn_reset_n        = 1'b0;
    trn_lnk_up_n       = 1'b0;
    bus.trn_rd         = '0;
    bus.trn_rrem_n     = 1'b0;
    bus.trn_rsof_n     = 1'b1;
    bus.trn_reof_n     = 1'b1;
    bus.trn_rsrc_rdy_n = 1'b1;
    bus.trn_rsrc_dsc_n = 1'b1;
    bus.trn_rerrfwd_n  = 1'b1;
    bus.trn_rbar_hit_n = 7'h7F;
    bus.tlp_ready      = 1'b0;
    err_cnt            = 0;

    // ---- reset state ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_rdst_rdy_n", bus.trn_rdst_rdy_n, 1);
    check_eq("rst_tlp_valid", bus.tlp_valid, 0);
    check_eq("rst_tlp_data", bus.tlp_data, 0);
    check_eq("rst_err_pulse", err_pulse, 0);
    tick();
    trn_reset_n = 1'b1;
    tick();
    @(negedge clk);
    check_eq("post_rst_rdst_rdy_n", bus.trn_rdst_rdy_n, 0);
    tick();

    // ---- 3-beat TLP and its output latency ----
    clear_obs();
    send(64'h1111_1111_1111_1111, 1, 0, 0, 0, 0, 7'h7E);
    send(64'h2222_2222_2222_2222, 0, 0, 0, 0, 1, 7'h7F);
    send(64'h3333_3333_3333_3333, 0, 1, 1, 0, 0, 7'h7F);
    @(negedge clk);
    check_eq("lat_edge_n", bus.tlp_valid, 0);
    @(negedge clk);
    check_eq("lat_edge_n1", bus.tlp_valid, 0);
    @(negedge clk);
    check_eq("lat_edge_n2", bus.tlp_valid, 1);
    check_eq("hold_data", bus.tlp_data, 64'h1111_1111_1111_1111);
    check_eq("hold_sof", bus.tlp_sof, 1);
    @(negedge clk);
    check_eq("hold_stable", bus.tlp_data, 64'h1111_1111_1111_1111);
    tick();
    drain(10);
    check_eq("t1_count", obs_q.size(), 3);
    expect_beat("t1_b0", 64'h1111_1111_1111_1111, 4'b1000, 7'h7E);
    expect_beat("t1_b1", 64'h2222_2222_2222_2222, 4'b0001, 7'h7E);
    expect_beat("t1_b2", 64'h3333_3333_3333_3333, 4'b0110, 7'h7E);
    check_eq("t1_err", err_cnt, 0);

    // ---- fill: 16 single-beat TLPs with consumer stalled ----
    clear_obs();
    for (int i = 0; i < 16; i++) begin
      logic [63:0] d;
      d = 64'hA000_0000_0000_0000 + 64'(i);
      send(d, 1, 1, 0, 0, 0, 7'h7E);
    end
    @(negedge clk);
    check_eq("full_rdst_rdy_n", bus.trn_rdst_rdy_n, 1);
    check_eq("full_head", bus.tlp_data, 64'hA000_0000_0000_0000);
    tick();
    bus.tlp_ready = 1'b1;
    tick();
    bus.tlp_ready = 1'b0;
    @(negedge clk);
    check_eq("unfull_rdst_rdy_n", bus.trn_rdst_rdy_n, 0);
    check_eq("unfull_head", bus.tlp_data, 64'hA000_0000_0000_0001);
    tick();
    drain(40);
    check_eq("fill_count", obs_q.size(), 16);
    for (int i = 0; i < 16; i++) begin
      logic [63:0] d;
      d = 64'hA000_0000_0000_0000 + 64'(i);
      expect_beat($sformatf("fill_%0d", i), d, 4'b1100, 7'h7E);
    end

    // ---- discontinue on beat 2, then a good TLP ----
    clear_obs();
    bus.tlp_ready = 1'b1;
    send(64'h41, 1, 0, 0, 0, 0, 7'h7D);
    send(64'h42, 0, 0, 0, 1, 0, 7'h7F);
    send(64'h51, 1, 0, 0, 0, 0, 7'h7D);
    send(64'h52, 0, 1, 0, 0, 0, 7'h7F);
    drain(10);
    check_eq("dsc_err", err_cnt, 1);
    check_eq("dsc_count", obs_q.size(), 2);
    expect_beat("dsc_b0", 64'h51, 4'b1000, 7'h7D);
    expect_beat("dsc_b1", 64'h52, 4'b0100, 7'h7D);

    // ---- oversize 20-beat TLP, then a good single-beat TLP ----
    clear_obs();
    bus.tlp_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      logic [63:0] d;
      d = 64'hB000 + 64'(i);
      send(d, (i == 0), (i == 19), 0, 0, 0, 7'h7E);
    end
    send(64'hB100, 1, 1, 0, 0, 0, 7'h7E);
    drain(10);
    check_eq("ovs_err", err_cnt, 1);
    check_eq("ovs_count", obs_q.size(), 1);
    expect_beat("ovs_good", 64'hB100, 4'b1100, 7'h7E);
`ifdef TRN_RX_STATS_EN
    check_eq("stat_drop_cnt", stat_drop_cnt, 2);
    check_eq("stat_tlp_cnt", stat_tlp_cnt, 19);
`endif

    // ---- sof mid-packet, then a beat without sof while idle ----
    clear_obs();
    bus.tlp_ready = 1'b1;
    send(64'h61, 1, 0, 0, 0, 0, 7'h7B);
    send(64'h62, 0, 0, 0, 0, 0, 7'h7F);
    send(64'h71, 1, 0, 0, 0, 0, 7'h77);
    send(64'h72, 0, 1, 0, 0, 0, 7'h7F);
    send(64'h81, 0, 1, 0, 0, 0, 7'h7F);
    send(64'h91, 1, 1, 0, 0, 0, 7'h6F);
    drain(10);
    check_eq("sof_err", err_cnt, 2);
    check_eq("sof_count", obs_q.size(), 3);
    expect_beat("sof_b0", 64'h71, 4'b1000, 7'h77);
    expect_beat("sof_b1", 64'h72, 4'b0100, 7'h77);
    expect_beat("sof_b2", 64'h91, 4'b1100, 7'h6F);

    // ---- link down mid-packet with one committed TLP queued ----
    clear_obs();
    send(64'hC1, 1, 1, 0, 0, 0, 7'h5F);
    send(64'hD1, 1, 0, 0, 0, 0, 7'h5F);
    send(64'hD2, 0, 0, 0, 0, 0, 7'h5F);
    trn_lnk_up_n = 1'b1;
    tick();
    @(negedge clk);
    check_eq("lnk_dn_rdst_rdy_n", bus.trn_rdst_rdy_n, 1);
    tick();
    drain(10);
    @(negedge clk);
    check_eq("lnk_dn_rdst_hold", bus.trn_rdst_rdy_n, 1);
    check_eq("lnk_dn_count", obs_q.size(), 1);
    expect_beat("lnk_dn_q", 64'hC1, 4'b1100, 7'h5F);
    tick();
    trn_lnk_up_n = 1'b0;
    tick();
    send(64'hE1, 1, 1, 1, 0, 0, 7'h3F);
    drain(10);
    check_eq("lnk_up_count", obs_q.size(), 1);
    expect_beat("lnk_up_b0", 64'hE1, 4'b1110, 7'h3F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
